// File: rtl/alu_exec_if.sv
// Operand/result bundle between the operand-mux stage, the execute stage and write-back.
interface alu_exec_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 3
);
  logic              en_in;
  logic [2:0]        alu_op;
  logic [DWIDTH-1:0] alu_a;
  logic [DWIDTH-1:0] alu_b;
  logic [AWIDTH-1:0] rd_tag;
  logic              busy;
  logic [DWIDTH-1:0] result;
  logic [AWIDTH-1:0] wb_tag;
  logic              flag_z;
  logic              flag_n;
  logic              flag_c;
  logic              flag_v;
  logic              en_out;

  // Upstream side: issues operands, watches busy and the result
  modport master (
    output en_in, alu_op, alu_a, alu_b, rd_tag,
    input  busy, result, wb_tag, flag_z, flag_n, flag_c, flag_v, en_out
  );

  // Execute stage side
  modport slave (
    input  en_in, alu_op, alu_a, alu_b, rd_tag,
    output busy, result, wb_tag, flag_z, flag_n, flag_c, flag_v, en_out
  );
endinterface

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ADD/SUB/logic/shift, iterative shift-add MUL.
// Result, flags and tag are registered and announced by a one-cycle en_out pulse.
module alu_exec #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  bus
);
  localparam int SW = $clog2(DWIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] result_q, result_d;
  logic [AWIDTH-1:0] wb_tag_q, wb_tag_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_v_q, flag_v_d;
  logic              en_out_q, en_out_d;
  logic              busy_q, busy_d;
  logic [DWIDTH-1:0] mul_a_q, mul_a_d;
  logic [DWIDTH-1:0] mul_b_q, mul_b_d;
  logic [DWIDTH-1:0] acc_q, acc_d;
  logic [AWIDTH-1:0] mul_tag_q, mul_tag_d;
  logic [SW-1:0]     cnt_q, cnt_d;

  logic [DWIDTH-1:0] op_res;
  logic              op_c;
  logic              op_v;
  logic [DWIDTH:0]   sum_w;
  logic [DWIDTH:0]   diff_w;
  logic [DWIDTH:0]   shl_w;
  logic [DWIDTH:0]   shr_w;
  logic [SW-1:0]     shamt;
  logic [DWIDTH-1:0] acc_step;

  // Single-cycle datapath; the extra bit on each wide vector is the carry/borrow/shift-out
  always_comb begin
    shamt  = bus.alu_b[SW-1:0];
    sum_w  = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    diff_w = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
    shl_w  = {1'b0, bus.alu_a} << shamt;
    shr_w  = {bus.alu_a, 1'b0} >> shamt;
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        op_res = sum_w[DWIDTH-1:0];
        op_c   = sum_w[DWIDTH];
        op_v   = (bus.alu_a[DWIDTH-1] == bus.alu_b[DWIDTH-1]) &&
                 (sum_w[DWIDTH-1] != bus.alu_a[DWIDTH-1]);
      end
      OP_SUB: begin
        op_res = diff_w[DWIDTH-1:0];
        op_c   = diff_w[DWIDTH];
        op_v   = (bus.alu_a[DWIDTH-1] != bus.alu_b[DWIDTH-1]) &&
                 (diff_w[DWIDTH-1] != bus.alu_a[DWIDTH-1]);
      end
      OP_AND: op_res = bus.alu_a & bus.alu_b;
      OP_OR:  op_res = bus.alu_a | bus.alu_b;
      OP_XOR: op_res = bus.alu_a ^ bus.alu_b;
      OP_SHL: begin
        op_res = shl_w[DWIDTH-1:0];
        op_c   = shl_w[DWIDTH];
      end
      OP_SHR: begin
        op_res = shr_w[DWIDTH:1];
        op_c   = shr_w[0];
      end
      default: ;
    endcase
  end

  // Next-state and output logic for the IDLE/MUL controller
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    wb_tag_d  = wb_tag_q;
    flag_z_d  = flag_z_q;
    flag_n_d  = flag_n_q;
    flag_c_d  = flag_c_q;
    flag_v_d  = flag_v_q;
    en_out_d  = 1'b0;
    busy_d    = busy_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    acc_d     = acc_q;
    mul_tag_d = mul_tag_q;
    cnt_d     = cnt_q;
    acc_step  = acc_q + (mul_b_q[0] ? mul_a_q : '0);
    case (state_q)
      S_IDLE: begin
        if (bus.en_in) begin
          if (bus.alu_op == OP_MUL) begin
            mul_a_d   = bus.alu_a;
            mul_b_d   = bus.alu_b;
            mul_tag_d = bus.rd_tag;
            acc_d     = '0;
            cnt_d     = SW'(DWIDTH - 1);
            busy_d    = 1'b1;
            state_d   = S_MUL;
          end else begin
            result_d = op_res;
            flag_c_d = op_c;
            flag_v_d = op_v;
            wb_tag_d = bus.rd_tag;
            en_out_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        // en_in is deliberately not looked at here: issuing while busy is dropped
        acc_d   = acc_step;
        mul_a_d = mul_a_q << 1;
        mul_b_d = mul_b_q >> 1;
        cnt_d   = cnt_q - SW'(1);
        if (cnt_q == '0) begin
          result_d = acc_step;
          flag_c_d = 1'b0;
          flag_v_d = 1'b0;
          wb_tag_d = mul_tag_q;
          en_out_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Z/N track the result only when a new one is written, so they hold with it
    if (en_out_d) begin
      flag_z_d = (result_d == '0);
      flag_n_d = result_d[DWIDTH-1];
    end
  end

  // State and output registers, cleared asynchronously so reset aborts a MUL at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      wb_tag_q  <= '0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_v_q  <= 1'b0;
      en_out_q  <= 1'b0;
      busy_q    <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      acc_q     <= '0;
      mul_tag_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      wb_tag_q  <= wb_tag_d;
      flag_z_q  <= flag_z_d;
      flag_n_q  <= flag_n_d;
      flag_c_q  <= flag_c_d;
      flag_v_q  <= flag_v_d;
      en_out_q  <= en_out_d;
      busy_q    <= busy_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      acc_q     <= acc_d;
      mul_tag_q <= mul_tag_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.result = result_q;
  assign bus.wb_tag = wb_tag_q;
  assign bus.flag_z = flag_z_q;
  assign bus.flag_n = flag_n_q;
  assign bus.flag_c = flag_c_q;
  assign bus.flag_v = flag_v_q;
  assign bus.en_out = en_out_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_alu_exec.sv
// Directed testbench for alu_exec: hand-computed vectors, one task per scenario.
module tb_alu_exec;
  localparam int DW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();
  alu_exec #(.DWIDTH(DW), .AWIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Back-to-back table: op, a, b, expected result, expected {z,n,c,v}
  localparam int NB = 9;
  logic [2:0]  t_op  [NB] = '{3'd5, 3'd6, 3'd6, 3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd5};
  logic [15:0] t_a   [NB] = '{16'h8001, 16'h0001, 16'h0003, 16'hF0F0, 16'hF0F0,
                              16'h0000, 16'h0001, 16'h8000, 16'h4000};
  logic [15:0] t_b   [NB] = '{16'h0001, 16'h0000, 16'h0001, 16'hFF00, 16'hFF00,
                              16'h0000, 16'h000F, 16'h0013, 16'h0012};
  logic [15:0] t_res [NB] = '{16'h0002, 16'h0001, 16'h0001, 16'h0FF0, 16'hF000,
                              16'h0000, 16'h8000, 16'h1000, 16'h0000};
  logic [3:0]  t_flg [NB] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                              4'b1000, 4'b0100, 4'b0000, 4'b1010};

  function automatic logic [3:0] flags();
    return {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] tag);
    bus.en_in  = 1'b1;
    bus.alu_op = op;
    bus.alu_a  = a;
    bus.alu_b  = b;
    bus.rd_tag = tag;
  endtask

  task automatic test_reset();
    bus.en_in = 1'b0; bus.alu_op = 3'd0; bus.alu_a = '0; bus.alu_b = '0; bus.rd_tag = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.result, bus.wb_tag, flags(), bus.en_out, bus.busy} !== 25'd0) begin
      failures++;
      $display("FAIL reset_state got res=%h tag=%0d zncv=%b en_out=%b busy=%b required all 0",
               bus.result, bus.wb_tag, flags(), bus.en_out, bus.busy);
    end
    $display("reset: res=%h tag=%0d zncv=%b en_out=%b busy=%b",
             bus.result, bus.wb_tag, flags(), bus.en_out, bus.busy);
  endtask

  task automatic test_add();
    @(negedge clk);
    drive(3'd0, 16'h7FFF, 16'h0001, 3'd3);
    checks++;
    if (bus.en_out !== 1'b0) begin
      failures++; $display("FAIL add_pre_en_out got=%b required=0", bus.en_out);
    end
    @(posedge clk);
    @(negedge clk);
    bus.en_in = 1'b0;
    $display("ADD 7fff+0001: res=%h tag=%0d zncv=%b en_out=%b", bus.result, bus.wb_tag, flags(), bus.en_out);
    checks++;
    if (bus.en_out !== 1'b1) begin
      failures++; $display("FAIL add_en_out got=%b required=1", bus.en_out);
    end
    checks++;
    if (bus.result !== 16'h8000 || bus.wb_tag !== 3'd3) begin
      failures++; $display("FAIL add_result got=%h/%0d required=8000/3", bus.result, bus.wb_tag);
    end
    checks++;
    if (flags() !== 4'b0101) begin
      failures++; $display("FAIL add_flags got zncv=%b required=0101", flags());
    end
    @(negedge clk);
    checks++;
    if (bus.en_out !== 1'b0 || bus.result !== 16'h8000) begin
      failures++; $display("FAIL add_pulse_width got en_out=%b res=%h required 0/8000", bus.en_out, bus.result);
    end
  endtask

  task automatic test_sub();
    @(negedge clk);
    drive(3'd1, 16'h0003, 16'h0005, 3'd1);
    @(posedge clk);
    @(negedge clk);
    drive(3'd1, 16'h1234, 16'h1234, 3'd2);
    $display("SUB 0003-0005: res=%h tag=%0d zncv=%b", bus.result, bus.wb_tag, flags());
    checks++;
    if (bus.en_out !== 1'b1 || bus.result !== 16'hFFFE || flags() !== 4'b0110) begin
      failures++;
      $display("FAIL sub_borrow got en=%b res=%h zncv=%b required 1/fffe/0110", bus.en_out, bus.result, flags());
    end
    @(posedge clk);
    @(negedge clk);
    bus.en_in = 1'b0;
    $display("SUB 1234-1234: res=%h tag=%0d zncv=%b", bus.result, bus.wb_tag, flags());
    checks++;
    if (bus.en_out !== 1'b1 || bus.result !== 16'h0000 || flags() !== 4'b1000 || bus.wb_tag !== 3'd2) begin
      failures++;
      $display("FAIL sub_zero got en=%b res=%h zncv=%b tag=%0d required 1/0000/1000/2",
               bus.en_out, bus.result, flags(), bus.wb_tag);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= NB; i++) begin
      @(negedge clk);
      if (i > 0) begin
        $display("b2b op=%0d a=%h b=%h: res=%h tag=%0d zncv=%b en_out=%b",
                 t_op[i-1], t_a[i-1], t_b[i-1], bus.result, bus.wb_tag, flags(), bus.en_out);
        checks++;
        if (bus.en_out !== 1'b1 || bus.result !== t_res[i-1] || flags() !== t_flg[i-1] ||
            bus.wb_tag !== 3'(i-1)) begin
          failures++;
          $display("FAIL b2b_%0d got en=%b res=%h zncv=%b tag=%0d required 1/%h/%b/%0d",
                   i-1, bus.en_out, bus.result, flags(), bus.wb_tag, t_res[i-1], t_flg[i-1], i-1);
        end
      end
      if (i < NB) drive(t_op[i], t_a[i], t_b[i], 3'(i));
      else bus.en_in = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (bus.en_out !== 1'b0) begin
      failures++; $display("FAIL b2b_idle_en_out got=%b required=0", bus.en_out);
    end
  endtask

  task automatic test_mul();
    int done_k = 0;
    int busy_cnt = 0;
    @(negedge clk);
    drive(3'd7, 16'h0012, 16'h0034, 3'd5);
    @(posedge clk);
    @(negedge clk);
    bus.en_in = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.en_out !== 1'b0) begin
      failures++; $display("FAIL mul_accept got busy=%b en_out=%b required 1/0", bus.busy, bus.en_out);
    end
    if (bus.busy === 1'b1) busy_cnt++;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 5) drive(3'd0, 16'h0001, 16'h0001, 3'd7);
      if (k == 6) bus.en_in = 1'b0;
      if (bus.en_out === 1'b1) begin
        done_k = k;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
    end
    bus.en_in = 1'b0;
    $display("MUL 0012*0034: res=%h tag=%0d zncv=%b done_cycle=%0d busy_cycles=%0d",
             bus.result, bus.wb_tag, flags(), done_k, busy_cnt);
    checks++;
    if (done_k != 16) begin
      failures++; $display("FAIL mul_latency got=%0d required=16 (0 = timeout)", done_k);
    end
    checks++;
    if (busy_cnt != 16 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL mul_busy got cycles=%0d busy_now=%b required 16/0", busy_cnt, bus.busy);
    end
    checks++;
    if (bus.result !== 16'h03A8 || bus.wb_tag !== 3'd5 || flags() !== 4'b0000) begin
      failures++;
      $display("FAIL mul_result got res=%h tag=%0d zncv=%b required 03a8/5/0000", bus.result, bus.wb_tag, flags());
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.en_out !== 1'b0 || bus.result !== 16'h03A8) begin
        failures++;
        $display("FAIL mul_ignored_add got en_out=%b res=%h required 0/03a8", bus.en_out, bus.result);
      end
    end
  endtask

  task automatic test_mul_wrap();
    int done_k = 0;
    @(negedge clk);
    drive(3'd7, 16'hFFFF, 16'hFFFF, 3'd4);
    @(posedge clk);
    @(negedge clk);
    bus.en_in = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.en_out === 1'b1) begin
        done_k = k;
        break;
      end
    end
    $display("MUL ffff*ffff: res=%h tag=%0d zncv=%b done_cycle=%0d", bus.result, bus.wb_tag, flags(), done_k);
    checks++;
    if (done_k != 16 || bus.result !== 16'h0001 || flags() !== 4'b0000 || bus.wb_tag !== 3'd4) begin
      failures++;
      $display("FAIL mul_wrap got cyc=%0d res=%h zncv=%b tag=%0d required 16/0001/0000/4",
               done_k, bus.result, flags(), bus.wb_tag);
    end
  endtask

  task automatic test_reset_mid_mul();
    int stray = 0;
    @(negedge clk);
    drive(3'd7, 16'h0012, 16'h0034, 3'd2);
    @(posedge clk);
    @(negedge clk);
    bus.en_in = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL midmul_busy_before got=%b required=1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    $display("reset mid-MUL: busy=%b en_out=%b res=%h", bus.busy, bus.en_out, bus.result);
    checks++;
    if (bus.busy !== 1'b0 || bus.en_out !== 1'b0 || bus.result !== 16'h0000) begin
      failures++;
      $display("FAIL midmul_async_reset got busy=%b en_out=%b res=%h required 0/0/0000",
               bus.busy, bus.en_out, bus.result);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.en_out !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++; $display("FAIL midmul_aborted got stray_cycles=%0d required=0", stray);
    end
    drive(3'd0, 16'h0002, 16'h0003, 3'd6);
    @(posedge clk);
    @(negedge clk);
    bus.en_in = 1'b0;
    $display("ADD 0002+0003: res=%h tag=%0d zncv=%b en_out=%b", bus.result, bus.wb_tag, flags(), bus.en_out);
    checks++;
    if (bus.en_out !== 1'b1 || bus.result !== 16'h0005 || bus.wb_tag !== 3'd6 || flags() !== 4'b0000) begin
      failures++;
      $display("FAIL add_after_reset got en=%b res=%h tag=%0d zncv=%b required 1/0005/6/0000",
               bus.en_out, bus.result, bus.wb_tag, flags());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_mul();
    test_mul_wrap();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
